// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM tick generator: FSM state encoding
// and the default counter width.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_tick_gen_if.sv
// Signal bundle between the PWM tick generator and its environment.
// The master drives tick/config, the slave (the generator) drives the waveform and status.
interface pwm_tick_gen_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
);

    logic             tick_src;
    logic             en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic             pwm_out;
    logic             period_done;
    logic             busy;
    logic             cfg_err;
    pwm_state_e       dbg_state;

    // No handshake: period_done acts as a one-cycle valid with an implied
    // always-ready consumer; it is never held or back-pressured, and
    // period/duty are sampled only on the tick that starts a period.
    modport master (
        output tick_src, en, period, duty,
        input  pwm_out, period_done, busy, cfg_err, dbg_state
    );

    modport slave (
        input  tick_src, en, period, duty,
        output pwm_out, period_done, busy, cfg_err, dbg_state
    );

endinterface

// File: rtl/pwm_tick_gen_tick_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the divided tick source.
// Produces a one-cycle tick whose FSM effect lands three clk_in edges after a rise.
module tick_sync_edge (
    input  logic clk_in,
    input  logic reset_n,
    input  logic tick_src,
    output logic tick_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic vld1_q;
    logic vld2_q;
    logic armed_q;
    logic armed_d;

    // Edges are only honoured once a genuine low sample has passed the
    // synchronizer, so a source already high at reset release is ignored.
    always_comb begin
        armed_d = armed_q | (vld2_q & ~sync2_q);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= tick_src;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            armed_q <= armed_d;
        end
    end

    assign tick_o = armed_q & sync2_q & ~prev_q;

endmodule

// File: rtl/pwm_tick_gen.sv
// PWM generator advancing one count per synchronized tick; period and duty are
// latched at period boundaries so reconfiguration never produces a partial period.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input logic           clk_in,
    input logic           reset_n,
    pwm_tick_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pwm_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] duty_q;
    logic             pwm_q;
    logic             done_q;
    logic             cfg_err_q;

    logic             tick;
    logic             at_boundary;
    logic             ld_zero;
    logic [CNT_W-1:0] ld_period;
    logic [CNT_W-1:0] cnt_inc;

    tick_sync_edge u_tick_sync_edge (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .tick_src (bus.tick_src),
        .tick_o   (tick)
    );

    // A zero period is loaded as one so the counter always wraps.
    always_comb begin
        ld_zero     = (bus.period == '0);
        ld_period   = ld_zero ? ONE : bus.period;
        at_boundary = (cnt_q == (period_q - ONE));
        cnt_inc     = cnt_q + ONE;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= ONE;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tick && bus.en) begin
                        state_q  <= RUN;
                        period_q <= ld_period;
                        duty_q   <= bus.duty;
                        cnt_q    <= '0;
                        pwm_q    <= (bus.duty != '0);
                        if (ld_zero) begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                RUN, STOP: begin
                    if (tick) begin
                        if (at_boundary) begin
                            done_q <= 1'b1;
                            cnt_q  <= '0;
                            if (bus.en) begin
                                state_q  <= RUN;
                                period_q <= ld_period;
                                duty_q   <= bus.duty;
                                pwm_q    <= (bus.duty != '0);
                                if (ld_zero) begin
                                    cfg_err_q <= 1'b1;
                                end
                            end else begin
                                state_q <= IDLE;
                                pwm_q   <= 1'b0;
                            end
                        end else begin
                            // Mid-period: STOP and RUN count identically, en only picks the state.
                            cnt_q   <= cnt_inc;
                            pwm_q   <= (cnt_inc < duty_q);
                            state_q <= bus.en ? RUN : STOP;
                        end
                    end else if (state_q == RUN && !bus.en) begin
                        state_q <= STOP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    pwm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_done = done_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cfg_err     = cfg_err_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Bench for pwm_tick_gen: a tick-level period model pushes expected
// (period length, high time) in clk cycles; a monitor measures each period.
module tb_pwm_tick_gen;
    import pwm_pkg::*;

    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_in = ~clk_in;

    pwm_tick_gen_if #(.CNT_W(CNT_W)) bus ();

    pwm_tick_gen #(.CNT_W(CNT_W)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: whole periods in ticks, nothing about counters or states.
    int tick_t    = 8;
    bit m_running = 0;
    int m_left    = 0;
    int m_len     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic note_fail(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic start_period();
        int high;
        m_len  = (bus.period == '0) ? 1 : int'(bus.period);
        high   = (int'(bus.duty) > m_len) ? m_len : int'(bus.duty);
        m_left = m_len;
        m_running = 1;
        exp_q.push_back({16'(m_len * tick_t), 16'(high * tick_t)});
    endtask

    task automatic model_tick();
        if (!m_running) begin
            if (bus.en) start_period();
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (bus.en) start_period();
                else m_running = 0;
            end
        end
    endtask

    function automatic int m_cnt();
        return m_len - m_left;
    endfunction

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    task automatic drive_tick(input bit chk_start);
        int hi;
        hi = tick_t / 2;
        bus.tick_src = 1'b1;
        model_tick();
        if (chk_start) begin
            repeat (2) @(negedge clk_in);
            check("start_latency_pre", 64'(bus.busy), 64'(0));
            @(negedge clk_in);
            check("start_latency", 64'(bus.busy), 64'(1));
            repeat (hi - 3) @(negedge clk_in);
        end else begin
            repeat (hi) @(negedge clk_in);
        end
        bus.tick_src = 1'b0;
        repeat (tick_t - hi) @(negedge clk_in);
    endtask

    task automatic run_to_idle(input string name);
        bus.en = 1'b0;
        for (int i = 0; i < 300 && m_running; i++) drive_tick(0);
        if (m_running) note_fail(name, "model never reached end of period");
        check({name, "_busy"}, 64'(bus.busy), 64'(0));
        check({name, "_pwm"}, 64'(bus.pwm_out), 64'(0));
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int len_c;
        int high_c;
        int rises;
        bit in_win;
        logic prev_pwm;
        logic [31:0] e;
        len_c = 0; high_c = 0; rises = 0; in_win = 0; prev_pwm = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!reset_n) begin
                in_win = 0;
                continue;
            end
            if (bus.period_done) begin
                if (!in_win) begin
                    note_fail("period_done_outside_run", "pulse with no active period");
                end else if (exp_q.size() == 0) begin
                    note_fail("period_done_unexpected", $sformatf("len=%0d high=%0d none expected", len_c, high_c));
                end else begin
                    e = exp_q.pop_front();
                    check("period_len_cycles", 64'(len_c), 64'(e[31:16]));
                    check("high_time_cycles", 64'(high_c), 64'(e[15:0]));
                    check("pwm_single_pulse", 64'(rises), 64'(0));
                end
            end
            if (bus.period_done || (bus.busy && !in_win) || !bus.busy) begin
                len_c = 0; high_c = 0; rises = 0;
                in_win = bus.busy;
            end
            if (in_win) begin
                len_c++;
                if (bus.pwm_out) high_c++;
                if (bus.pwm_out && !prev_pwm && len_c > 1) rises++;
            end
            prev_pwm = bus.pwm_out;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bus.tick_src = 1'b0;
        bus.en       = 1'b0;
        bus.period   = 8'd4;
        bus.duty     = 8'd1;
        repeat (3) @(negedge clk_in);
        check("reset_pwm", 64'(bus.pwm_out), 64'(0));
        check("reset_done", 64'(bus.period_done), 64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_cfg_err", 64'(bus.cfg_err), 64'(0));
        check("reset_state", 64'(bus.dbg_state), 64'(IDLE));
        reset_n = 1'b1;
        repeat (4) @(negedge clk_in);

        // divider-style tick every 24 cycles, period 4 duty 1 -> done every 96 cycles
        tick_t = 24;
        bus.en = 1'b1;
        drive_tick(1);
        check("first_pwm_high", 64'(bus.pwm_out), 64'(1));
        repeat (12) drive_tick(0);
        run_to_idle("div24_stop");

        // duty 0 then duty 9 with period 8
        tick_t     = 8;
        bus.period = 8'd8;
        bus.duty   = 8'd0;
        bus.en     = 1'b1;
        drive_tick(1);
        repeat (8) drive_tick(0);
        bus.duty = 8'd9;
        repeat (16) drive_tick(0);

        // duty 2 -> 6 mid-period
        bus.duty = 8'd2;
        for (int i = 0; i < 20 && m_cnt() != 0; i++) drive_tick(0);
        repeat (3) drive_tick(0);
        bus.duty = 8'd6;
        repeat (13) drive_tick(0);
        run_to_idle("duty_change");

        // randomized config and run-request traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) bus.period = 8'($urandom_range(1, 10));
            if ($urandom_range(0, 3) == 0) bus.duty   = 8'($urandom_range(0, 12));
            bus.en = ($urandom_range(0, 9) != 0);
            drive_tick(0);
        end
        run_to_idle("random");

        // en dropped at cnt 2: STOP, finish the period, then idle
        bus.period = 8'd8;
        bus.duty   = 8'd3;
        bus.en     = 1'b1;
        drive_tick(1);
        for (int i = 0; i < 20 && m_cnt() != 2; i++) drive_tick(0);
        bus.en = 1'b0;
        drive_tick(0);
        check("en_drop_state_stop", 64'(bus.dbg_state), 64'(STOP));
        run_to_idle("en_drop");
        check("en_drop_state_idle", 64'(bus.dbg_state), 64'(IDLE));

        // en dropped at cnt 2 and re-raised at cnt 5: continuous run
        bus.en = 1'b1;
        drive_tick(1);
        for (int i = 0; i < 20 && m_cnt() != 2; i++) drive_tick(0);
        bus.en = 1'b0;
        for (int i = 0; i < 20 && m_cnt() != 5; i++) drive_tick(0);
        bus.en = 1'b1;
        drive_tick(0);
        check("en_reraise_state_run", 64'(bus.dbg_state), 64'(RUN));
        repeat (10) drive_tick(0);
        run_to_idle("en_reraise");

        // period 0 is loaded as 1 and latches cfg_err
        check("cfg_err_before", 64'(bus.cfg_err), 64'(0));
        bus.period = 8'd0;
        bus.duty   = 8'd1;
        bus.en     = 1'b1;
        drive_tick(1);
        check("cfg_err_set", 64'(bus.cfg_err), 64'(1));
        repeat (3) drive_tick(0);
        bus.duty = 8'd0;
        repeat (3) drive_tick(0);
        run_to_idle("period_zero");
        check("cfg_err_sticky", 64'(bus.cfg_err), 64'(1));

        // reset mid-period with tick_src held high
        bus.period = 8'd8;
        bus.duty   = 8'd6;
        bus.en     = 1'b1;
        drive_tick(1);
        repeat (3) drive_tick(0);
        bus.tick_src = 1'b1;
        repeat (5) @(negedge clk_in);
        check("pre_reset_pwm", 64'(bus.pwm_out), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pwm", 64'(bus.pwm_out), 64'(0));
        check("async_reset_busy", 64'(bus.busy), 64'(0));
        check("async_reset_done", 64'(bus.period_done), 64'(0));
        check("async_reset_cfg_err", 64'(bus.cfg_err), 64'(0));
        check("async_reset_state", 64'(bus.dbg_state), 64'(IDLE));
        exp_q.delete();
        m_running = 0;
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_in);
        check("no_spurious_tick_busy", 64'(bus.busy), 64'(0));
        bus.tick_src = 1'b0;
        repeat (4) @(negedge clk_in);
        drive_tick(1);
        repeat (8) drive_tick(0);
        run_to_idle("after_reset");

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
